// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the branch-prediction shadow entry.
// Types and constants only; no logic state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_INC = 32'd4;

    typedef struct packed {
        logic  valid;
        word_t pc;
        logic  hit;
        word_t bp_pc;
    } bp_shadow_t;

    function automatic word_t seq_pc(input word_t pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/branch_shadow_pipe.sv
// Shift register carrying fetch-time BTB predictions to EX; DEPTH cycles of latency.
// Holds while en=0; clr empties every entry and takes priority over en.
module branch_shadow_pipe
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       en,
    input  logic       clr,
    input  bp_shadow_t in_entry,
    output bp_shadow_t ex_entry
);

    bp_shadow_t entry_q [DEPTH];
    bp_shadow_t entry_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i] = '0;
            end
        end else if (en) begin
            entry_d[0] = in_entry;
            for (int i = 1; i < DEPTH; i++) begin
                entry_d[i] = entry_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    assign ex_entry = entry_q[DEPTH-1];

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: compares the carried BTB prediction with the real outcome.
// Outputs registered (1-cycle latency); pipe_en=0 stalls resolution and the shadow pipe.
module branch_resolver
    import cpu_types_pkg::*;
#(
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             pipe_en,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_btb_hit,
    input  logic [31:0]      if_bp_pc,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             btb_update,
    output logic [31:0]      update_pc,
    output logic [31:0]      branch_target,
    output logic             desync,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic             flush_q, flush_d;
    word_t            redirect_pc_q, redirect_pc_d;
    logic             btb_update_q, btb_update_d;
    word_t            update_pc_q, update_pc_d;
    word_t            branch_target_q, branch_target_d;
    logic             desync_q, desync_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    bp_shadow_t if_entry;
    bp_shadow_t ex_entry;
    logic       resolve;
    logic       mispredict;
    word_t      pred_pc;
    word_t      actual_pc;

    assign if_entry = '{valid: if_valid, pc: if_pc, hit: if_btb_hit, bp_pc: if_bp_pc};

    // The flush cycle both empties the shadow pipe and blocks capture of the wrong-path fetch.
    branch_shadow_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_shadow (
        .CLK      (CLK),
        .nRST     (nRST),
        .en       (pipe_en),
        .clr      (flush_q),
        .in_entry (if_entry),
        .ex_entry (ex_entry)
    );

    assign resolve    = pipe_en & ex_valid & ~flush_q;
    assign pred_pc    = (ex_entry.valid & ex_entry.hit) ? ex_entry.bp_pc : seq_pc(ex_pc);
    assign actual_pc  = (ex_is_branch & ex_taken) ? ex_target : seq_pc(ex_pc);
    assign mispredict = (actual_pc != pred_pc);

    always_comb begin
        flush_d          = 1'b0;
        redirect_pc_d    = '0;
        btb_update_d     = 1'b0;
        update_pc_d      = update_pc_q;
        branch_target_d  = branch_target_q;
        desync_d         = desync_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (resolve) begin
            flush_d         = mispredict;
            redirect_pc_d   = actual_pc;
            btb_update_d    = mispredict & ex_is_branch & ex_taken;
            update_pc_d     = ex_pc;
            branch_target_d = ex_target;
            if (ex_entry.valid && (ex_entry.pc != ex_pc)) begin
                desync_d = 1'b1;
            end
            if (ex_is_branch && (branch_cnt_q != '1)) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (mispredict && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            flush_q          <= 1'b0;
            redirect_pc_q    <= '0;
            btb_update_q     <= 1'b0;
            update_pc_q      <= '0;
            branch_target_q  <= '0;
            desync_q         <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
            btb_update_q     <= btb_update_d;
            update_pc_q      <= update_pc_d;
            branch_target_q  <= branch_target_d;
            desync_q         <= desync_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign btb_update     = btb_update_q;
    assign update_pc      = update_pc_q;
    assign branch_target  = branch_target_q;
    assign desync         = desync_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (PIPE_DEPTH=2, CNT_W=4) with hand-computed expectations.
module tb_branch_resolver;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             pipe_en;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic             if_btb_hit;
    logic [31:0]      if_bp_pc;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_is_branch;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             btb_update;
    logic [31:0]      update_pc;
    logic [31:0]      branch_target;
    logic             desync;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    branch_resolver #(
        .PIPE_DEPTH (2),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .pipe_en        (pipe_en),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_btb_hit     (if_btb_hit),
        .if_bp_pc       (if_bp_pc),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .btb_update     (btb_update),
        .update_pc      (update_pc),
        .branch_target  (branch_target),
        .desync         (desync),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_if(input logic v, input logic [31:0] pc, input logic hit, input logic [31:0] bp);
        if_valid   = v;
        if_pc      = pc;
        if_btb_hit = hit;
        if_bp_pc   = bp;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                            input logic [31:0] tgt);
        ex_valid     = v;
        ex_pc        = pc;
        ex_is_branch = br;
        ex_taken     = tk;
        ex_target    = tgt;
    endtask

    task automatic do_reset();
        nRST    = 1'b0;
        pipe_en = 1'b1;
        drive_if(1'b0, 32'h0, 1'b0, 32'h0);
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        nRST = 1'b1;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_flush"}, 32'(flush), 32'h0);
        check_eq({pfx, "_redirect"}, redirect_pc, 32'h0);
        check_eq({pfx, "_btb_update"}, 32'(btb_update), 32'h0);
        check_eq({pfx, "_update_pc"}, update_pc, 32'h0);
        check_eq({pfx, "_branch_target"}, branch_target, 32'h0);
        check_eq({pfx, "_desync"}, 32'(desync), 32'h0);
        check_eq({pfx, "_branch_cnt"}, 32'(branch_cnt), 32'h0);
        check_eq({pfx, "_mispredict_cnt"}, 32'(mispredict_cnt), 32'h0);
    endtask

    // Fetch one PC, then let it travel the two shadow stages so it aligns with EX.
    task automatic fetch_and_align(input logic [31:0] pc, input logic hit, input logic [31:0] bp);
        drive_if(1'b1, pc, hit, bp);
        tick();
        drive_if(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
    endtask

    initial begin
        do_reset();
        check_all_zero("reset");

        // Correctly predicted taken branch
        fetch_and_align(32'h100, 1'b1, 32'h200);
        drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
        tick();
        check_eq("hit_flush", 32'(flush), 32'h0);
        check_eq("hit_btb_update", 32'(btb_update), 32'h0);
        check_eq("hit_branch_cnt", 32'(branch_cnt), 32'd1);
        check_eq("hit_mispredict_cnt", 32'(mispredict_cnt), 32'd0);
        check_eq("hit_update_pc", update_pc, 32'h100);
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        // Cold miss on taken branch; a younger hit entry is fetched alongside
        do_reset();
        fetch_and_align(32'h40, 1'b0, 32'h0);
        drive_ex(1'b1, 32'h40, 1'b1, 1'b1, 32'h80);
        drive_if(1'b1, 32'h44, 1'b1, 32'h500);
        tick();
        check_eq("cold_flush", 32'(flush), 32'h1);
        check_eq("cold_redirect", redirect_pc, 32'h80);
        check_eq("cold_btb_update", 32'(btb_update), 32'h1);
        check_eq("cold_update_pc", update_pc, 32'h40);
        check_eq("cold_branch_target", branch_target, 32'h80);
        check_eq("cold_mispredict_cnt", 32'(mispredict_cnt), 32'd1);
        // Flush cycle: wrong-path EX and fetch must be ignored
        drive_ex(1'b1, 32'h44, 1'b1, 1'b1, 32'h999);
        drive_if(1'b1, 32'h48, 1'b1, 32'h600);
        tick();
        check_eq("wp_flush", 32'(flush), 32'h0);
        check_eq("wp_redirect", redirect_pc, 32'h0);
        check_eq("wp_btb_update", 32'(btb_update), 32'h0);
        check_eq("wp_branch_cnt", 32'(branch_cnt), 32'd1);
        check_eq("wp_mispredict_cnt", 32'(mispredict_cnt), 32'd1);
        check_eq("wp_update_pc", update_pc, 32'h40);
        // A stale 0x44->0x500 entry would mispredict this sequential instruction
        drive_if(1'b0, 32'h0, 1'b0, 32'h0);
        drive_ex(1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("clr_flush", 32'(flush), 32'h0);
        check_eq("clr_update_pc", update_pc, 32'h44);
        check_eq("clr_branch_cnt", 32'(branch_cnt), 32'd1);
        check_eq("clr_desync", 32'(desync), 32'h0);
        drive_ex(1'b1, 32'h48, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("nocap_flush", 32'(flush), 32'h0);
        check_eq("nocap_mispredict_cnt", 32'(mispredict_cnt), 32'd1);

        // Predicted taken, resolved not-taken
        do_reset();
        fetch_and_align(32'h104, 1'b1, 32'h300);
        drive_ex(1'b1, 32'h104, 1'b1, 1'b0, 32'h300);
        tick();
        check_eq("nt_flush", 32'(flush), 32'h1);
        check_eq("nt_redirect", redirect_pc, 32'h108);
        check_eq("nt_btb_update", 32'(btb_update), 32'h0);
        check_eq("nt_mispredict_cnt", 32'(mispredict_cnt), 32'd1);
        check_eq("nt_branch_target", branch_target, 32'h300);
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        // Stall with a mispredicting branch held in EX
        do_reset();
        fetch_and_align(32'h40, 1'b0, 32'h0);
        pipe_en = 1'b0;
        drive_ex(1'b1, 32'h40, 1'b1, 1'b1, 32'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("stall_flush_%0d", i), 32'(flush), 32'h0);
        end
        pipe_en = 1'b1;
        tick();
        check_eq("stall_rel_flush", 32'(flush), 32'h1);
        check_eq("stall_rel_redirect", redirect_pc, 32'h80);
        check_eq("stall_rel_mispredict_cnt", 32'(mispredict_cnt), 32'd1);
        check_eq("stall_desync", 32'(desync), 32'h0);
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("stall_after_flush", 32'(flush), 32'h0);
        check_eq("stall_after_mispredict_cnt", 32'(mispredict_cnt), 32'd1);

        // Shadow PC disagrees with EX PC: sticky desync, prediction still from E
        fetch_and_align(32'h10, 1'b0, 32'h0);
        drive_ex(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("desync_set", 32'(desync), 32'h1);
        check_eq("desync_flush", 32'(flush), 32'h0);
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check_eq("desync_sticky", 32'(desync), 32'h1);

        // Reset asserted during the flush cycle
        do_reset();
        fetch_and_align(32'h40, 1'b0, 32'h0);
        drive_ex(1'b1, 32'h40, 1'b1, 1'b1, 32'h80);
        tick();
        check_eq("rstfl_flush", 32'(flush), 32'h1);
        nRST = 1'b0;
        tick();
        check_all_zero("rstfl");
        nRST = 1'b1;
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Counter saturation at 4 bits
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_ex(1'b1, 32'h1000, 1'b1, 1'b1, 32'h2000);
            tick();
            drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
            if (i == 14) begin
                check_eq("sat15_mispredict_cnt", 32'(mispredict_cnt), 32'd15);
            end
        end
        check_eq("sat_mispredict_cnt", 32'(mispredict_cnt), 32'd15);
        check_eq("sat_branch_cnt", 32'(branch_cnt), 32'd15);

        // ex_pc+4 wraps to zero
        do_reset();
        fetch_and_align(32'hFFFF_FFFC, 1'b1, 32'h50);
        drive_ex(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h50);
        tick();
        check_eq("wrap_flush", 32'(flush), 32'h1);
        check_eq("wrap_redirect", redirect_pc, 32'h0);
        check_eq("wrap_update_pc", update_pc, 32'hFFFF_FFFC);
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit; the writer side of the four-entry branch target buffer. It carries each fetched instruction's BTB prediction (hit, predicted PC) down a shadow pipeline aligned with the fetch-to-execute stages. It compares that prediction with the branch outcome computed in EX. On a misprediction it issues a one-cycle pipeline flush with the correct redirect PC, and writes taken-branch targets back into the BTB.

## Interface

Parameters
- PIPE_DEPTH, 2: number of pipeline registers between fetch and EX; range 1–4.
- CNT_W, 32: width of the performance counters.

Ports
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- pipe_en  in  1  pipeline advance. 0 means stall: the shadow pipe holds and no resolution occurs.
- if_valid  in  1  fetch-stage instruction valid.
- if_pc  in  32  fetch PC; drives BTB curr_pc externally.
- if_btb_hit  in  1  BTB hit for if_pc.
- if_bp_pc  in  32  BTB predicted target for if_pc.
- ex_valid  in  1  EX-stage instruction valid.
- ex_pc  in  32  EX instruction PC.
- ex_is_branch  in  1  EX instruction is a conditional branch or jump.
- ex_taken  in  1  branch resolved taken.
- ex_target  in  32  resolved branch target.
- flush  out  1  one-cycle pulse. It squashes IF and ID/EX-side stages and redirects fetch.
- redirect_pc  out  32  correct next PC; valid while flush=1.
- btb_update  out  1  BTB write enable; drives the BTB branch_flush input.
- update_pc  out  32  PC of the branch being written to the BTB.
- branch_target  out  32  target value written to the BTB.
- desync  out  1  sticky error: shadow entry PC ≠ ex_pc at resolution.
- branch_cnt  out  CNT_W  count of resolved branches.
- mispredict_cnt  out  CNT_W  count of resolved mispredictions.

## Operation

- Shadow pipe: PIPE_DEPTH entries, each holding {valid, pc, hit, bp_pc}.
  - When pipe_en=1: entry[0] ← {if_valid, if_pc, if_btb_hit, if_bp_pc}, and entry[i] ← entry[i-1].
  - When pipe_en=0: all entries hold.
  - entry[PIPE_DEPTH-1] is the EX-aligned entry E.
- Resolution occurs in a cycle where pipe_en=1, ex_valid=1 and flush=0:
  - pred_pc = (E.valid & E.hit) ? E.bp_pc : ex_pc+4.
  - actual = (ex_is_branch & ex_taken) ? ex_target : ex_pc+4.
  - mispredict = (actual ≠ pred_pc). This includes BTB aliasing on a non-branch, which redirects to ex_pc+4.
  - btb_wr = mispredict & ex_is_branch & ex_taken.
  - If E.valid & (E.pc ≠ ex_pc), set desync. The prediction still uses E as-is.
- Outputs are registered. Resolution in cycle N produces the following in cycle N+1:
  - flush = mispredict.
  - redirect_pc = actual.
  - btb_update = btb_wr.
  - update_pc = ex_pc.
  - branch_target = ex_target.
  - flush, redirect_pc and btb_update are 0 in every other cycle. update_pc and branch_target hold their last values.
- Flush cycle (flush=1):
  - All shadow entries are cleared to valid=0, regardless of pipe_en.
  - The if_* inputs are not captured.
  - ex_* inputs are ignored; that instruction is wrong-path.
- Counters: branch_cnt increments on each resolution with ex_is_branch=1. mispredict_cnt increments on each resolution with mispredict=1. Both saturate at 2^CNT_W−1 and do not wrap.
- PC arithmetic is mod 2^32; ex_pc+4 wraps 0xFFFFFFFC → 0x00000000.

## Timing

- Reset (nRST=0 at a rising edge) sets every output and register to 0:
  - flush, redirect_pc, btb_update, update_pc, branch_target, desync, both counters.
  - All shadow valid bits.
- Reset asserted mid-flush or mid-stall takes priority over every other action.
- Resolution-to-flush latency is 1 cycle. The BTB sees btb_update at the same edge that fetch redirects.
- A stall (pipe_en=0) in cycle N suppresses resolution in cycle N. Resolution happens exactly once, in the first cycle with pipe_en=1.
- Back-to-back mispredictions cannot occur: the cycle after a flush never resolves.

## Structure

- cpu_types_pkg gains:
  - bp_shadow_t (packed struct: valid, pc word_t, hit, bp_pc word_t).
  - Constant PC_INC = 32'd4.
- One sub-module: branch_shadow_pipe. It holds the parameterized entry shift register with enable and clear, and exposes entry[PIPE_DEPTH-1].
- Resolution logic, output registers and counters stay in branch_resolver.

## Test plan

- Correctly predicted taken branch:
  - Stimulus: fetch 0x100 with hit=1, bp_pc=0x200, PIPE_DEPTH=2; after 2 advances, EX 0x100 branch taken to 0x200.
  - Required: flush=0, btb_update=0, branch_cnt=1, mispredict_cnt=0.
- Cold miss on taken branch:
  - Stimulus: hit=0 at 0x40; EX taken to 0x80.
  - Required: next cycle flush=1, redirect_pc=0x80, btb_update=1, update_pc=0x40, branch_target=0x80. All shadow valid=0 the following cycle.
- Predicted taken, resolved not-taken:
  - Stimulus: hit=1, bp_pc=0x300 at 0x104; EX not taken.
  - Required: flush=1, redirect_pc=0x108, btb_update=0, mispredict_cnt incremented.
- Stall during resolution:
  - Stimulus: pipe_en=0 for 3 cycles with a mispredicting branch held in EX.
  - Required: no flush during the stall. Exactly one flush pulse, the cycle after pipe_en returns to 1. mispredict_cnt increments by exactly 1.
- Flush ignores wrong path; reset mid-flush:
  - Stimulus: ex_valid=1 with a mispredicting branch in the flush cycle.
  - Required: no second flush and no counter change.
  - Stimulus: nRST=0 during the flush cycle.
  - Required: all outputs 0 at the next edge.
- Saturation and wrap:
  - Stimulus: CNT_W=4, 20 mispredicting branches.
  - Required: mispredict_cnt=15.
  - Stimulus: EX at 0xFFFFFFFC, not taken, after hit=1.
  - Required: redirect_pc=0x00000000.
